// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, opcode field layout, default widths.
// The HALT state only exists when FETCH_HALT_EN is defined.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  // Opcode occupies the top OPC_W bits of a ROM word; operand starts at bit OPD_LSB.
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned OPD_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3
`ifdef FETCH_HALT_EN
    ,
    ST_HALT    = 3'd4
`endif
  } fetch_state_e;

  // Bit index of the opcode LSB for a given word width.
  function automatic int unsigned opc_lsb(input int unsigned data_w);
    return data_w - OPC_W;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// Program counter: loads on redirect, increments on capture, wraps modulo 2^ADDR_W.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next PC: redirect has priority over increment; increment wraps silently.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  // PC register with synchronous reset to address 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads the ROM, presents decoded words to control.
// Optional feature macro: FETCH_HALT_EN (opcode OPC_HALT parks fetch until a redirect).
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OPC_W-1:0]  opcode,
  output logic [ADDR_W-1:0] operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic              halted
);

  localparam int unsigned OPC_LSB = opc_lsb(DATA_W);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [ADDR_W-1:0] pc;

  logic              rom_rd_q,      rom_rd_d;
  logic [ADDR_W-1:0] rom_addr_q,    rom_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic [OPC_W-1:0]  opcode_q,      opcode_d;
  logic [ADDR_W-1:0] operand_q,     operand_d;
  logic [ADDR_W-1:0] instr_pc_q,    instr_pc_d;

  logic              capture_c;
  logic              handshake_c;
  logic [OPC_W-1:0]  rom_opc_c;
  logic [ADDR_W-1:0] rom_opd_c;
  logic              unused_rom_bits;

  // Field split of the returning ROM word; bits between the fields are ignored.
  assign rom_opc_c       = rom_data[OPC_LSB +: OPC_W];
  assign rom_opd_c       = rom_data[OPD_LSB +: ADDR_W];
  assign unused_rom_bits = ^rom_data;

  // A ROM word is only kept when no redirect arrives in the same cycle.
  assign capture_c   = (state_q == ST_WAIT) && !jmp_valid;
  assign handshake_c = instr_valid_q && instr_ready;

  pc_counter #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .clk         (clk),
    .reset       (reset),
    .load_i      (jmp_valid),
    .load_addr_i (jmp_addr),
    .inc_i       (capture_c),
    .pc_o        (pc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a redirect overrides every state.
  always_comb begin
    state_d = state_q;
    if (jmp_valid) begin
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_FETCH;
        ST_FETCH:   state_d = ST_WAIT;
        ST_WAIT:    state_d = ST_PRESENT;
        ST_PRESENT: begin
          if (handshake_c) begin
`ifdef FETCH_HALT_EN
            state_d = (opcode_q == OPC_HALT) ? ST_HALT : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
          end
        end
`ifdef FETCH_HALT_EN
        ST_HALT:    state_d = ST_HALT;
`endif
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output next values, derived from the upcoming state so outputs line up with it.
  always_comb begin
    rom_rd_d      = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_PRESENT);
    rom_addr_d    = rom_addr_q;
    opcode_d      = opcode_q;
    operand_d     = operand_q;
    instr_pc_d    = instr_pc_q;
    if (state_d == ST_FETCH) begin
      rom_addr_d = jmp_valid ? jmp_addr : pc;
    end
    if (capture_c) begin
      opcode_d   = rom_opc_c;
      operand_d  = rom_opd_c;
      instr_pc_d = pc;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_rd_q      <= 1'b0;
      rom_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      opcode_q      <= '0;
      operand_q     <= '0;
      instr_pc_q    <= '0;
    end else begin
      rom_rd_q      <= rom_rd_d;
      rom_addr_q    <= rom_addr_d;
      instr_valid_q <= instr_valid_d;
      opcode_q      <= opcode_d;
      operand_q     <= operand_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q;
  logic halted_d;

  assign halted_d = (state_d == ST_HALT);

  // Halt flag register, cleared by reset or by leaving HALT.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign rom_rd      = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign instr_valid = instr_valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of the CPU `control` block. It owns the program counter and drives the single read port of `rom`. It splits each fetched word into `opcode` and `operand`, then presents it to `control` through a valid/ready handshake. It also accepts jump redirects back from `control`.

## Interface
- `DATA_W`, 16: ROM word width; the instruction layout is {opcode[3:0], unused, operand[ADDR_W-1:0]}; requires DATA_W >= ADDR_W+4
- `ADDR_W`, 8: ROM address width and program counter width
- `clk` input 1: single clock; everything updates on its rising edge
- `reset` input 1: synchronous, active-high
- `rom_rd` output 1: ROM read strobe
- `rom_addr` output ADDR_W: ROM read address
- `rom_data` input DATA_W: ROM read data, valid one cycle after `rom_rd`
- `instr_valid` output 1: an instruction is presented to `control`
- `instr_ready` input 1: `control` accepts the presented instruction
- `opcode` output 4: rom_data[DATA_W-1:DATA_W-4] of the presented instruction
- `operand` output ADDR_W: rom_data[ADDR_W-1:0] of the presented instruction
- `instr_pc` output ADDR_W: address the presented instruction was fetched from
- `jmp_valid` input 1: redirect request from `control`
- `jmp_addr` input ADDR_W: redirect target
- `halted` output 1: fetch is stopped on a halt opcode

## Operation
- State machine states: IDLE, FETCH, WAIT, PRESENT, HALT.
- Reset: state=IDLE, pc=0.
  - Registered outputs reset to 0: `rom_rd`, `rom_addr`, `instr_valid`, `opcode`, `operand`, `instr_pc`, `halted`.
- IDLE -> FETCH unconditionally.
- FETCH: `rom_rd`=1, `rom_addr`=pc, then go to WAIT.
- WAIT: capture `rom_data` into `opcode` and `operand`, set `instr_pc`=pc, set pc=pc+1, then go to PRESENT.
- PRESENT: `instr_valid`=1.
  - Outputs stay stable until `instr_valid && instr_ready`.
  - On that handshake go to FETCH, or to HALT when the halt rule applies.
- PC arithmetic is modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0 with no flag.
- `jmp_valid` wins over everything in any non-reset state:
  - Next cycle: pc=jmp_addr, state=FETCH, `instr_valid`=0, `halted`=0.
  - An in-flight ROM word (state WAIT) is discarded.
- `jmp_valid` in PRESENT together with `instr_ready`: the handshake counts as completed, and the redirect sets pc.
- `reset` has priority over `jmp_valid`. Reset mid-fetch discards all in-flight data.
- `control` must not raise `instr_ready` as a combinational function of `instr_valid`. `fetch_unit` never depends combinationally on `instr_ready`.

## Timing
- `rom_rd` is asserted for exactly one cycle per fetch.
- Cycle after reset deassertion: IDLE. Next cycle: FETCH, with `rom_rd` high.
- `instr_valid` rises 2 cycles after the `rom_rd` cycle.
- Throughput: one instruction per 3 cycles when `instr_ready` is held high.
- Redirect latency: `jmp_valid` in cycle N gives `rom_rd` with `rom_addr`=jmp_addr in cycle N+1.

## Configuration
- `FETCH_HALT_EN` defined:
  - Opcode 4'hF is the halt opcode. It is presented and handshaken normally, after which the state goes to HALT.
  - In HALT: `halted`=1, `rom_rd`=0, `instr_valid`=0.
  - HALT exits only on `jmp_valid` or `reset`.
- `FETCH_HALT_EN` undefined:
  - 4'hF is fetched like any other opcode.
  - `halted` is tied to 0 and the HALT state does not exist.

## Structure
- Shared package `cpu_pkg` holds:
  - the fetch state enum,
  - `OPC_HALT` = 4'hF,
  - default `DATA_W` and `ADDR_W`,
  - opcode field position localparams, also used by `control`.
- One sub-module, `pc_counter`:
  - loads on redirect, increments on capture, wraps modulo 2^ADDR_W;
  - synchronous active-high `reset` to 0.

## Test plan
- Reset released, ROM[0]=16'h1005, `instr_ready`=1 -> `rom_rd` in cycle 1 with `rom_addr`=0; cycle 3 gives `instr_valid`=1, `opcode`=1, `operand`=8'h05, `instr_pc`=0.
- `instr_ready`=0 for 5 cycles while PRESENT -> outputs stable, no `rom_rd`. Raising `instr_ready` gives `rom_rd` with `rom_addr`=1 the following cycle.
- `jmp_valid`=1 with `jmp_addr`=8'h40 during WAIT -> the captured word is discarded, the next `rom_rd` has `rom_addr`=8'h40, and the presented `instr_pc`=8'h40.
- pc=8'hFF fetch completes -> next `rom_addr`=8'h00.
- With FETCH_HALT_EN and ROM[3]=16'hF000 -> after the handshake `halted`=1 and `rom_rd` stays 0 for 20 cycles. `jmp_valid` with `jmp_addr`=0 then clears `halted` and fetches address 0.
- `reset` asserted during PRESENT -> next cycle all outputs are 0 and pc=0.
